// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, response codes, FSM states.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [1:0] LSU_OK  = 2'b00;
  localparam logic [1:0] LSU_MIS = 2'b01;
  localparam logic [1:0] LSU_TMO = 2'b10;
  localparam logic [1:0] LSU_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 != LSU_B) && (funct3 != LSU_H) && (funct3 != LSU_W);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response interface and data-memory bus interface of the load/store unit.
interface lsu_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface lsu_bus_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (output bus_valid, bus_we, bus_be, bus_addr, bus_wdata,
                  input  bus_ready, bus_rdata);
  modport slave  (input  bus_valid, bus_we, bus_be, bus_addr, bus_wdata,
                  output bus_ready, bus_rdata);
endinterface

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, store replication, load extraction and extension.
// Misalign detection is only active when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  lane;
  logic [15:0] half;

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    lane      = rdata[{off, 3'b000} +: 8];
    half      = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LSU_B, LSU_BU: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = funct3[2] ? {24'b0, lane} : {{24{lane[7]}}, lane};
      end
      LSU_H, LSU_HU: begin
        be        = 4'b0011 << {off[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = funct3[2] ? {16'b0, half} : {{16{half[15]}}, half};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (funct3)
      LSU_H, LSU_HU: misaligned = off[0];
      LSU_W:         misaligned = (off != 2'b00);
      default:       misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// Load/store unit: one bus transaction per core request, with optional bus timeout.
// state | meaning
// IDLE  | ready for a request; req_ready high
// BUS   | bus_valid held until bus_ready or timeout
// RESP  | one-cycle response strobe to writeback
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rstn,
  lsu_core_if.slave  core,
  lsu_bus_if.master  bus
);

  lsu_state_e  state, state_next;
  logic [1:0]  err_next;
  logic [31:0] cnt;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic        accept, illegal, timeout_hit;

  logic [2:0]  sel_funct3;
  logic [1:0]  sel_off;
  logic [3:0]  be;
  logic [31:0] wdata_rep, rdata_ext;
  logic        misaligned;

  logic        bus_valid_q, bus_we_q, rsp_valid_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_addr_q, bus_wdata_q, rsp_rdata_q;
  logic [1:0]  rsp_err_q;

  // The aligner sees the live request while idle and the latched one afterwards.
  assign sel_funct3 = (state == IDLE) ? core.req_funct3     : lat_funct3;
  assign sel_off    = (state == IDLE) ? core.req_addr[1:0]  : lat_off;

  lsu_align u_align (
    .funct3     (sel_funct3),
    .off        (sel_off),
    .wdata      (core.req_wdata),
    .rdata      (bus.bus_rdata),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  assign accept      = core.req_valid && (state == IDLE);
  assign illegal     = funct3_illegal(core.req_we, core.req_funct3);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state;
    err_next   = LSU_OK;
    case (state)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_next = RESP;
            err_next   = LSU_ILL;
          end else if (misaligned) begin
            state_next = RESP;
            err_next   = LSU_MIS;
          end else begin
            state_next = BUS;
          end
        end
      end
      BUS: begin
        if (bus.bus_ready) begin
          state_next = RESP;
        end else if (timeout_hit) begin
          state_next = RESP;
          err_next   = LSU_TMO;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_funct3  <= '0;
      lat_off     <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= LSU_OK;
    end else begin
      state       <= state_next;
      cnt         <= (state == BUS && state_next == BUS) ? cnt + 32'd1 : '0;
      rsp_valid_q <= (state_next == RESP);
      rsp_err_q   <= (state_next == RESP) ? err_next : LSU_OK;
      rsp_rdata_q <= (state == BUS && bus.bus_ready && !bus_we_q) ? rdata_ext : '0;
      if (accept) begin
        lat_funct3  <= core.req_funct3;
        lat_off     <= core.req_addr[1:0];
        bus_we_q    <= core.req_we;
        bus_be_q    <= be;
        bus_addr_q  <= {core.req_addr[31:2], 2'b00};
        bus_wdata_q <= wdata_rep;
        bus_valid_q <= (state_next == BUS);
      end else if (state == BUS && state_next != BUS) begin
        bus_valid_q <= 1'b0;
      end
    end
  end

  assign core.req_ready = (state == IDLE);
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_rdata = rsp_rdata_q;
  assign core.rsp_err   = rsp_err_q;
  assign bus.bus_valid  = bus_valid_q;
  assign bus.bus_we     = bus_we_q;
  assign bus.bus_be     = bus_be_q;
  assign bus.bus_addr   = bus_addr_q;
  assign bus.bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against an arithmetic reference model (TIMEOUT_CYCLES = 4).
module tb_lsu;

  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  lsu_core_if core ();
  lsu_bus_if  bus ();

  lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .core (core),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: err (ignoring timeout), byte enables, word address, bus data, load result.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       output logic [1:0] err, output logic [3:0] be, output logic [31:0] baddr,
                       output logic [31:0] bwdata, output logic [31:0] rsp);
    int unsigned o, hs;
    logic [31:0] v;
    logic ill, mis;
    o     = addr % 4;
    hs    = (addr / 2) % 2;
    ill   = we ? (f3 > 2) : (f3 == 3 || f3 >= 6);
    mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (!ill) mis = ((f3 % 4 == 1) && (addr % 2 == 1)) || ((f3 == 2) && (o != 0));
`endif
    baddr = addr - o;
    case (f3 % 4)
      0: begin
        be = 4'(1 << o);
        bwdata = (wdata & 32'hFF) * 32'h01010101;
        v = (rdata >> (8 * o)) & 32'hFF;
        if (f3 < 4 && v >= 128) v = v - 32'd256;
      end
      1: begin
        be = 4'(3 << (2 * hs));
        bwdata = (wdata & 32'hFFFF) * 32'h00010001;
        v = (rdata >> (16 * hs)) & 32'hFFFF;
        if (f3 < 4 && v >= 32768) v = v - 32'd65536;
      end
      default: begin
        be = 4'hF;
        bwdata = wdata;
        v = rdata;
      end
    endcase
    err = ill ? 2'b11 : (mis ? 2'b01 : 2'b00);
    rsp = (err == 2'b00 && !we) ? v : 32'd0;
  endtask

  // d = bus wait cycles before bus_ready; d >= TMO leads to a timeout.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int d);
    logic [1:0] e;
    logic [3:0] be;
    logic [31:0] ba, bw, rd;
    model(we, f3, addr, wdata, rdata, e, be, ba, bw, rd);
    @(negedge clk);
    core.req_valid = 1'b1;
    core.req_we = we;
    core.req_funct3 = f3;
    core.req_addr = addr;
    core.req_wdata = wdata;
    bus.bus_rdata = rdata;
    bus.bus_ready = 1'b0;
    check("idle_rsp_valid", 32'(core.rsp_valid), 0);
    check("req_ready", 32'(core.req_ready), 1);
    @(posedge clk);
    #1;
    // Noise on the request lines while busy must be ignored.
    core.req_valid = 1'(($urandom() >> 5) & 1);
    core.req_addr = $urandom();
    core.req_funct3 = 3'($urandom());
    core.req_wdata = $urandom();
    if (e != 2'b00) begin
      @(negedge clk);
      core.req_valid = 1'b0;
      check("err_rsp_valid", 32'(core.rsp_valid), 1);
      check("err_code", 32'(core.rsp_err), 32'(e));
      check("err_rdata", core.rsp_rdata, 0);
      check("err_no_bus", 32'(bus.bus_valid), 0);
      check("err_req_ready", 32'(core.req_ready), 0);
    end else begin
      for (int j = 0; j < int'(TMO); j++) begin
        @(negedge clk);
        check("bus_valid", 32'({bus.bus_valid, core.rsp_valid}), 32'b10);
        check("bus_we", 32'(bus.bus_we), 32'(we));
        check("bus_be", 32'(bus.bus_be), 32'(be));
        check("bus_addr", bus.bus_addr, ba);
        if (we) check("bus_wdata", bus.bus_wdata, bw);
        if (j == d) begin
          bus.bus_ready = 1'b1;
          break;
        end
      end
      @(negedge clk);
      core.req_valid = 1'b0;
      bus.bus_ready = 1'b0;
      bus.bus_rdata = ~rdata;
      check("rsp_valid", 32'(core.rsp_valid), 1);
      check("rsp_err", 32'(core.rsp_err), (d < int'(TMO)) ? 32'd0 : 32'd2);
      check("rsp_rdata", core.rsp_rdata, (d < int'(TMO)) ? rd : 32'd0);
      check("rsp_bus_valid", 32'(bus.bus_valid), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    core.req_valid = 1'b0;
    core.req_we = 1'b0;
    core.req_funct3 = 3'b000;
    core.req_addr = '0;
    core.req_wdata = '0;
    bus.bus_ready = 1'b0;
    bus.bus_rdata = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus", 32'({bus.bus_valid, bus.bus_we, bus.bus_be}), 0);
    check("rst_bus_addr", bus.bus_addr, 0);
    check("rst_bus_wdata", bus.bus_wdata, 0);
    check("rst_rsp", 32'({core.rsp_valid, core.rsp_err}), 0);
    check("rst_rsp_rdata", core.rsp_rdata, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(core.req_ready), 1);

    run_req(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1);
    run_req(1'b0, 3'b000, 32'h103, 32'h0, 32'h80000000, 0);
    run_req(1'b0, 3'b100, 32'h103, 32'h0, 32'h80000000, 2);
    run_req(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0);
    run_req(1'b0, 3'b101, 32'h202, 32'h0, 32'hABCD1234, 1);
    run_req(1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0);
    run_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h12345678, 10);
    run_req(1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 3);
    run_req(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0);
    run_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);

    // Reset while the bus is waiting: no response may follow.
    @(negedge clk);
    core.req_valid = 1'b1;
    core.req_we = 1'b1;
    core.req_funct3 = 3'b010;
    core.req_addr = 32'h300;
    core.req_wdata = 32'h11223344;
    bus.bus_ready = 1'b0;
    @(posedge clk);
    #1;
    core.req_valid = 1'b0;
    @(negedge clk);
    check("mid_bus_valid", 32'(bus.bus_valid), 1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_bus_valid", 32'(bus.bus_valid), 0);
    check("mid_rst_rsp_valid", 32'(core.rsp_valid), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(core.req_ready), 1);
    check("mid_rst_no_rsp", 32'(core.rsp_valid), 0);

    for (int i = 0; i < 80; i++) begin
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
              $urandom(), $urandom(), int'($urandom_range(0, 5)));
    end

    @(negedge clk);
    check("final_rsp_valid", 32'(core.rsp_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
